// File: rtl/fifo_rx_check.sv
// rtl/fifo_rx_check.sv - Read-side FIFO consumer checking a SEED+index word sequence
// Optional feature macro: RX_THROTTLE_EN (LFSR-driven read back-pressure)
module fifo_rx_check #(
   parameter int WID       = 8,
   parameter int CNT_W     = 8,
   parameter int NUM_WORDS = 128,
   parameter int SEED      = 10
) (
   input  logic             read_clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WID-1:0]   fifo_data,
   input  logic             fifo_empty,
   output logic             rd_en,
   output logic [WID-1:0]   rx_data,
   output logic             rx_valid,
   output logic [CNT_W-1:0] rx_count,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] first_err_idx,
   output logic [WID-1:0]   first_err_data,
   output logic             busy,
   output logic             done,
   output logic             pass
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t         state, state_nxt;
   logic           stall;
   logic           clear;
   logic           mismatch;
   logic [WID-1:0] exp_word;

`ifdef RX_THROTTLE_EN
   // Fibonacci LFSR, taps 8,6,5,4; free-running in every state
   logic [7:0] lfsr;
   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) lfsr <= 8'hA5;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end
   assign stall = (lfsr[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      clear     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               clear     = 1'b1;
            end
         end
         RUN: begin
            busy  = 1'b1;
            rd_en = !fifo_empty && !stall;
            if (rd_en && (rx_count == LAST_IDX)) state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt = RUN;
               clear     = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Expected word uses the count before this pop increments it
   assign exp_word = WID'(SEED) + WID'(rx_count);
   assign mismatch = (fifo_data != exp_word);

   always_ff @(posedge read_clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         rx_count       <= '0;
         err_count      <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
      end else begin
         rx_valid <= rd_en;
         if (clear) begin
            rx_count       <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
         end else if (rd_en) begin
            rx_data  <= fifo_data;
            rx_count <= rx_count + CNT_W'(1);
            if (mismatch) begin
               if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
               if (err_count == '0) begin
                  first_err_idx  <= rx_count;
                  first_err_data <= fifo_data;
               end
            end
         end
      end
   end

   assign pass = done && (err_count == '0);

endmodule

// File: doc/fifo_rx_check.md
# fifo_rx_check

Read-side consumer for the asynchronous FIFO, clocked in the read domain. It pops words with a show-ahead `rd_en` handshake and checks each word against the sequence the write-side ROM source produces (`SEED + index`, modulo 2^`WID`). It counts words and mismatches, captures the first error, and reports pass/fail after `NUM_WORDS` words. It is the receiving end of the FIFO loopback test path.

## Interface
- `WID`, 8: data word width.
- `CNT_W`, 8: width of the word and error counters.
- `NUM_WORDS`, 128: words per run; legal range 1 .. 2^`CNT_W`-1.
- `SEED`, 10: expected value of word 0.

- `read_clk` in 1: the only clock; all state is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a run.
- `fifo_data` in `WID`: FIFO head word; valid whenever `fifo_empty`=0 (show-ahead).
- `fifo_empty` in 1: FIFO empty flag, already synchronised to `read_clk`.
- `rd_en` out 1: pop strobe; the FIFO advances on an edge where `rd_en`=1.
- `rx_data` out `WID`: registered copy of the last popped word.
- `rx_valid` out 1: one-cycle pulse; `rx_data` is new.
- `rx_count` out `CNT_W`: words popped in this run.
- `err_count` out `CNT_W`: mismatches in this run; saturates at all-ones.
- `first_err_idx` out `CNT_W`: index of the first mismatching word.
- `first_err_data` out `WID`: value received at that index.
- `busy` out 1: high in the RUN state.
- `done` out 1: high in the DONE state.
- `pass` out 1: `done` and `err_count`=0.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- IDLE, `start`=1: go to RUN and clear `rx_count`, `err_count`, `first_err_idx` and `first_err_data`.
- RUN:
  - `rd_en` = RUN & !`fifo_empty` & !`stall`. `stall` is 0 unless `RX_THROTTLE_EN` is defined.
  - On a pop edge, `rx_data` <= `fifo_data` and `rx_count` increments.
  - The word is compared with `exp` = (`SEED` + `rx_count`) mod 2^`WID`, using the pre-increment count.
  - On a mismatch, `err_count` increments (saturating). If `err_count` was 0, `first_err_idx` <= `rx_count` and `first_err_data` <= `fifo_data`.
- RUN to DONE: on the edge of the pop that makes `rx_count` equal `NUM_WORDS`.
- DONE:
  - `rd_en`=0; all counters and captures hold.
  - `start`=1 restarts: go to RUN and clear, exactly as from IDLE.
- `start` has no effect while in RUN.
- If `fifo_empty`=1 in RUN, `rd_en`=0 and no state changes. The block waits indefinitely; there is no timeout.
- Expected-value arithmetic wraps modulo 2^`WID`. For example, `SEED`=250 with `WID`=8 gives word 6 the value 0.

## Timing
- Reset values: `rd_en`=0, `rx_data`=0, `rx_valid`=0, all counters and captures 0, `busy`=0, `done`=0, `pass`=0.
- Asserting `rst_n` mid-run forces `rd_en` low immediately, without waiting for a clock edge. All state clears.
- `rd_en` is combinational from state, `fifo_empty` and `stall`. It may be high on consecutive cycles, giving one word per cycle.
- Latency: pop edge N gives `rx_valid`=1, new `rx_data` and updated counters in cycle N+1.
- `busy` rises in the cycle after `start` is sampled.
- Status timing relative to the final pop edge:
  - `done` and `pass` are valid in the cycle after that edge.
  - `busy` falls in that same cycle.
  - `err_count` already includes the final word.
- A mismatch on the final word is counted before `pass` is evaluated.

## Configuration
- Macro: `RX_THROTTLE_EN`.
- When defined:
  - An 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) is seeded to 8'hA5 on reset and advances every `read_clk` cycle, in every state.
  - `stall` = (`lfsr[1:0]`==2'b00). This applies random back-pressure to the FIFO read side for roughly 25 % of cycles.
- When not defined:
  - The LFSR is not built and `stall` is tied to 0.
  - `rd_en` is high in every RUN cycle where `fifo_empty`=0.

## Test plan
- Clean run: `SEED`=10, `NUM_WORDS`=128, FIFO pre-loaded with 10..137 and never empty. Expect 128 `rd_en` cycles back-to-back, then `done`=1, `pass`=1, `rx_count`=128, `err_count`=0.
- Single error: word 5 is corrupted to 8'hFF. Expect `err_count`=1, `first_err_idx`=5, `first_err_data`=8'hFF, `pass`=0.
- Empty gaps: `fifo_empty` high for 3 cycles after every 4 words. Expect `rd_en`=0 during each gap and no count change; the run still completes with `pass`=1.
- Reset mid-run: pull `rst_n` low after 40 words. Expect `rd_en`=0 and all outputs 0 without a clock edge. After reset is released and `start` is pulsed, the run checks from word 0 again (expects 10).
- Restart and wrap: `SEED`=250, `NUM_WORDS`=20, data 250..255,0..13. Expect `pass`=1. A second `start` while in DONE clears the counters and a repeated run passes. `start` pulsed mid-run is ignored.
- Throttle (`RX_THROTTLE_EN` defined): FIFO never empty. Expect `rd_en`=0 exactly in the cycles where `lfsr[1:0]`==0. The first LFSR values after reset match a reference model seeded 8'hA5. The run completes with `pass`=1.
